// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Purpose  : 8-bit execute-stage ALU. Implements logic, 1-bit shift,
//            add/subtract and pass-through operations, selected by a 4-bit
//            command. The result and the carry/shift-out flag are registered,
//            so the outputs appear one clock cycle after the inputs.
// Ports    : clk            - system clock, rising edge active
//            rst_n          - asynchronous active-low reset
//            alu_cmd[3:0]   - operation select (1000-1111 reserved)
//            inA[7:0]       - operand A
//            inB[7:0]       - operand B
//            shiftcarry_in  - bit shifted into the vacated position on shifts
//            rslt[7:0]      - registered result
//            shiftcarry_out - registered carry / borrow / shifted-out bit
// Revision : 1.0 - initial release
// ============================================================================
module alu_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] alu_cmd,
    input  logic [7:0] inA,
    input  logic [7:0] inB,
    input  logic       shiftcarry_in,
    output logic [7:0] rslt,
    output logic       shiftcarry_out
);

    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_XOR  = 4'b0001;
    localparam logic [3:0] c_OP_OR   = 4'b0010;
    localparam logic [3:0] c_OP_LSL  = 4'b0011;
    localparam logic [3:0] c_OP_LSR  = 4'b0100;
    localparam logic [3:0] c_OP_ADD  = 4'b0101;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_PASS = 4'b0111;

    // 9-bit arithmetic: bit 8 of the sum is the carry; bit 8 of the
    // zero-extended difference is set exactly when inA < inB (borrow).
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_rslt_nxt;
    logic       w_co_nxt;
    logic [7:0] r_rslt;
    logic       r_co;

    assign w_sum  = {1'b0, inA} + {1'b0, inB};
    assign w_diff = {1'b0, inA} - {1'b0, inB};

    always_comb begin
        w_rslt_nxt = 8'h00;
        w_co_nxt   = 1'b0;
        case (alu_cmd)
            c_OP_AND:  w_rslt_nxt = inA & inB;
            c_OP_XOR:  w_rslt_nxt = inA ^ inB;
            c_OP_OR:   w_rslt_nxt = inA | inB;
            c_OP_LSL: begin
                w_rslt_nxt = {inA[6:0], shiftcarry_in};
                w_co_nxt   = inA[7];
            end
            c_OP_LSR: begin
                w_rslt_nxt = {shiftcarry_in, inA[7:1]};
                w_co_nxt   = inA[0];
            end
            c_OP_ADD: begin
                w_rslt_nxt = w_sum[7:0];
                w_co_nxt   = w_sum[8];
            end
            c_OP_SUB: begin
                w_rslt_nxt = w_diff[7:0];
                w_co_nxt   = w_diff[8];
            end
            c_OP_PASS: w_rslt_nxt = inA;
            // Reserved commands keep the zero defaults so no X escapes.
            default: begin
                w_rslt_nxt = 8'h00;
                w_co_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rslt <= 8'h00;
            r_co   <= 1'b0;
        end else begin
            r_rslt <= w_rslt_nxt;
            r_co   <= w_co_nxt;
        end
    end

    assign rslt           = r_rslt;
    assign shiftcarry_out = r_co;

endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_core
// Purpose  : Self-checking bench for alu_core. Directed vectors for each
//            operation class, randomized streams against an arithmetic
//            reference model, reserved commands and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] alu_cmd;
    logic [7:0] inA;
    logic [7:0] inB;
    logic       shiftcarry_in;
    logic [7:0] rslt;
    logic       shiftcarry_out;

    int passed = 0;
    int total  = 0;

    alu_core u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_cmd        (alu_cmd),
        .inA            (inA),
        .inB            (inB),
        .shiftcarry_in  (shiftcarry_in),
        .rslt           (rslt),
        .shiftcarry_out (shiftcarry_out)
    );

    always #5 clk = ~clk;

    // Reference model: returns {carry_out, result} from plain integer arithmetic.
    function automatic logic [8:0] model(input logic [3:0] cmd, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci);
        int ia, ib, r, co;
        ia = int'(a);
        ib = int'(b);
        r  = 0;
        co = 0;
        case (int'(cmd))
            0: r = int'(a & b);
            1: r = int'(a ^ b);
            2: r = int'(a | b);
            3: begin r = (ia * 2) % 256 + int'(ci);       co = (ia >= 128) ? 1 : 0; end
            4: begin r = ia / 2 + (ci ? 128 : 0);         co = ia % 2;              end
            5: begin r = ia + ib; co = (r >= 256) ? 1 : 0; r = r % 256;             end
            6: begin r = ia - ib; co = (r < 0) ? 1 : 0; if (r < 0) r = r + 256;     end
            7: r = ia;
            default: begin r = 0; co = 0; end
        endcase
        return {co[0], r[7:0]};
    endfunction

    // Drive one operation at the falling edge, let it be captured, settle.
    task automatic step(input logic [3:0] cmd, input logic [7:0] a,
                        input logic [7:0] b, input logic ci);
        @(negedge clk);
        alu_cmd = cmd; inA = a; inB = b; shiftcarry_in = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_cmd = 4'($urandom); inA = 8'($urandom); inB = 8'($urandom);
        shiftcarry_in = 1'($urandom);
        #2;
        total++;
        if ({shiftcarry_out, rslt} !== 9'h000)
            $display("FAIL reset_async: rslt=%h co=%b, expected rslt=00 co=0", rslt, shiftcarry_out);
        else passed++;
        alu_cmd = 4'd5; inA = 8'hFF; inB = 8'h01;
        @(posedge clk); #1;
        total++;
        if ({shiftcarry_out, rslt} !== 9'h000)
            $display("FAIL reset_held: rslt=%h co=%b, expected rslt=00 co=0", rslt, shiftcarry_out);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_logic();
        logic [3:0] cmds [4] = '{4'd0, 4'd1, 4'd2, 4'd7};
        logic [7:0] exps [4] = '{8'h00, 8'hFF, 8'hFF, 8'hAA};
        for (int i = 0; i < 4; i++) begin
            step(cmds[i], 8'hAA, 8'h55, 1'b0);
            total++;
            if ({shiftcarry_out, rslt} !== {1'b0, exps[i]})
                $display("FAIL logic cmd=%h: rslt=%h co=%b, expected rslt=%h co=0",
                         cmds[i], rslt, shiftcarry_out, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_shift();
        logic [3:0] cmds [4] = '{4'd3, 4'd4, 4'd3, 4'd4};
        logic       cis  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [8:0] exps [4] = '{9'h154, 9'h055, 9'h155, 9'h0D5};
        for (int i = 0; i < 4; i++) begin
            step(cmds[i], 8'hAA, 8'($urandom), cis[i]);
            total++;
            if ({shiftcarry_out, rslt} !== exps[i])
                $display("FAIL shift cmd=%h ci=%b: rslt=%h co=%b, expected rslt=%h co=%b",
                         cmds[i], cis[i], rslt, shiftcarry_out, exps[i][7:0], exps[i][8]);
            else passed++;
        end
    endtask

    task automatic test_add();
        logic [7:0] as   [3] = '{8'hAA, 8'hFF, 8'h80};
        logic [7:0] bs   [3] = '{8'h55, 8'h01, 8'h80};
        logic [8:0] exps [3] = '{9'h0FF, 9'h100, 9'h100};
        for (int i = 0; i < 3; i++) begin
            step(4'd5, as[i], bs[i], 1'($urandom));
            total++;
            if ({shiftcarry_out, rslt} !== exps[i])
                $display("FAIL add %h+%h: rslt=%h co=%b, expected rslt=%h co=%b",
                         as[i], bs[i], rslt, shiftcarry_out, exps[i][7:0], exps[i][8]);
            else passed++;
        end
    endtask

    task automatic test_sub();
        logic [7:0] as   [4] = '{8'hAA, 8'h55, 8'h00, 8'h7F};
        logic [7:0] bs   [4] = '{8'h55, 8'hAA, 8'h01, 8'h7F};
        logic [8:0] exps [4] = '{9'h055, 9'h1AB, 9'h1FF, 9'h000};
        for (int i = 0; i < 4; i++) begin
            step(4'd6, as[i], bs[i], 1'($urandom));
            total++;
            if ({shiftcarry_out, rslt} !== exps[i])
                $display("FAIL sub %h-%h: rslt=%h co=%b, expected rslt=%h co=%b",
                         as[i], bs[i], rslt, shiftcarry_out, exps[i][7:0], exps[i][8]);
            else passed++;
        end
    endtask

    task automatic test_reserved();
        for (int c = 8; c < 16; c++) begin
            step(4'(c), 8'($urandom), 8'($urandom), 1'($urandom));
            total++;
            if ({shiftcarry_out, rslt} !== 9'h000)
                $display("FAIL reserved cmd=%h: rslt=%h co=%b, expected rslt=00 co=0",
                         4'(c), rslt, shiftcarry_out);
            else passed++;
        end
    endtask

    // Changes the command every cycle; before each edge the outputs must
    // still reflect the previous operation, after it the new one.
    task automatic test_back_to_back();
        logic [8:0] prev;
        logic [8:0] exp;
        logic [3:0] cmd;
        logic [7:0] a, b;
        logic       ci;
        prev = {shiftcarry_out, rslt};
        for (int i = 0; i < 60; i++) begin
            cmd = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15))
                                              : 4'($urandom_range(0, 7));
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
            exp = model(cmd, a, b, ci);
            @(negedge clk);
            total++;
            if ({shiftcarry_out, rslt} !== prev)
                $display("FAIL b2b_hold[%0d]: rslt=%h co=%b, expected rslt=%h co=%b",
                         i, rslt, shiftcarry_out, prev[7:0], prev[8]);
            else passed++;
            alu_cmd = cmd; inA = a; inB = b; shiftcarry_in = ci;
            @(posedge clk); #1;
            total++;
            if ({shiftcarry_out, rslt} !== exp)
                $display("FAIL b2b[%0d] cmd=%h a=%h b=%h ci=%b: rslt=%h co=%b, expected rslt=%h co=%b",
                         i, cmd, a, b, ci, rslt, shiftcarry_out, exp[7:0], exp[8]);
            else passed++;
            prev = exp;
        end
    endtask

    task automatic test_midstream_reset();
        logic [8:0] exp;
        step(4'd5, 8'hFF, 8'hFF, 1'b0);
        total++;
        if ({shiftcarry_out, rslt} !== 9'h1FE)
            $display("FAIL mid_pre: rslt=%h co=%b, expected rslt=FE co=1", rslt, shiftcarry_out);
        else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({shiftcarry_out, rslt} !== 9'h000)
            $display("FAIL mid_async_clear: rslt=%h co=%b, expected rslt=00 co=0", rslt, shiftcarry_out);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({shiftcarry_out, rslt} !== 9'h000)
            $display("FAIL mid_held: rslt=%h co=%b, expected rslt=00 co=0", rslt, shiftcarry_out);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        alu_cmd = 4'd4; inA = 8'h81; inB = 8'h00; shiftcarry_in = 1'b1;
        exp = model(4'd4, 8'h81, 8'h00, 1'b1);
        @(posedge clk); #1;
        total++;
        if ({shiftcarry_out, rslt} !== exp)
            $display("FAIL mid_resume: rslt=%h co=%b, expected rslt=%h co=%b",
                     rslt, shiftcarry_out, exp[7:0], exp[8]);
        else passed++;
    endtask

    task automatic test_random();
        logic [8:0] exp;
        logic [3:0] cmd;
        logic [7:0] a, b;
        logic       ci;
        for (int i = 0; i < 200; i++) begin
            cmd = 4'($urandom_range(0, 7));
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
            exp = model(cmd, a, b, ci);
            step(cmd, a, b, ci);
            total++;
            if ({shiftcarry_out, rslt} !== exp)
                $display("FAIL rand[%0d] cmd=%h a=%h b=%h ci=%b: rslt=%h co=%b, expected rslt=%h co=%b",
                         i, cmd, a, b, ci, rslt, shiftcarry_out, exp[7:0], exp[8]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_shift();
        test_add();
        test_sub();
        test_reserved();
        test_back_to_back();
        test_midstream_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
